ref_shallow_ram_be_init: RTL and testbench
==========================================

Name: ref_shallow_ram_be_init

Overview:
- Single-clock, distributed-RAM shallow memory. Next generation of the team's inferred shallow RAM.
- Adds byte-enable writes, qualified reads with a valid strobe, an optional output pipeline register, and a selectable read/write collision mode (write-through bypass or read-first).
- After every reset, a state machine clears the whole array to a programmable value.
- Used for small descriptor/context tables in the DMA reference design.

Parameters:
- ADDR_WIDTH, 5: address bits; NUM_WORDS = 2^ADDR_WIDTH.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8: localparam, number of byte enables.
- OUT_REG, 0: 1 adds an output register stage (read latency 2 instead of 1).
- BYPASS, 1: 1 = same-address collision returns newly written bytes; 0 = returns old contents (read-first).
- INIT_VALUE, {DATA_WIDTH{1'b0}}: word written to every location by the clear sequence.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  BE_WIDTH  byte enables; bit i covers wr_data[8i+7:8i].
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle strobe marking rd_data valid.
- init_busy  out  1  clear sequence in progress; rd_en and wr_en are ignored while high.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: rd_data=0, rd_valid=0, init_busy=1, pipeline stages cleared, clear counter=0.
- FSM states: CLEAR, READY.
  - rst forces CLEAR with counter=0.
  - In CLEAR, each cycle with rst low writes INIT_VALUE to mem[counter], then increments the counter.
  - After the write to NUM_WORDS-1, the FSM moves to READY. init_busy drops on the cycle after that final write.
  - init_busy is high for exactly NUM_WORDS cycles after the first rst-low edge.
- Reset mid-clear: the clear restarts from address 0. Reset in READY re-enters CLEAR; contents are re-cleared.
- Write (READY, wr_en=1): at the edge, mem[wr_addr] bytes with wr_be[i]=1 take wr_data; other bytes are unchanged. wr_be=0 is a no-op.
- Read (READY, rd_en=1 at edge n):
  - OUT_REG=0: rd_data holds the word and rd_valid=1 after edge n (latency 1).
  - OUT_REG=1: same, after edge n+1 (latency 2).
  - rd_valid is high for exactly one cycle per accepted read.
  - Back-to-back reads give one result per cycle.
- rd_data holds its last value when rd_valid=0. It is not cleared by completed reads, only by rst.
- Collision (rd_en, wr_en, rd_addr==wr_addr in the same cycle):
  - BYPASS=1: returned word = per byte, wr_data where wr_be=1, else old mem contents.
  - BYPASS=0: returned word = old contents. The write still completes.
  - Different addresses: no interaction.
- Requests while init_busy=1 are dropped: no write, no rd_valid, no queuing.
- Reads in flight when rst asserts are discarded: rd_valid=0 on the next cycle.
- Addresses use the full range; no wrap logic is needed; NUM_WORDS-1 is valid.
- No x outputs after reset under any input sequence.

Test Plan:
- Clear sequence: ADDR_WIDTH=5, INIT_VALUE=32'hA5A5A5A5; release rst -> init_busy high exactly 32 cycles; then reads of addrs 0,17,31 return A5A5A5A5 with rd_valid one cycle after rd_en.
- Byte enables: write 32'h11223344 be=4'hF to addr 3, then 32'hFFEEDDCC be=4'b0101 -> read addr 3 returns 32'h11EE33CC.
- Collision: mem[7]=32'h0; same cycle rd_en+wr_en addr 7, data 32'hDEADBEEF, be=4'b0011 -> BYPASS=1 returns 32'h0000BEEF; BYPASS=0 returns 32'h0; a subsequent read returns 32'h0000BEEF in both modes.
- Latency/throughput: OUT_REG=1, reads of addrs 0..31 on consecutive cycles -> rd_valid continuous for 32 cycles starting 2 cycles after the first rd_en, data in order.
- Reset mid-clear: assert rst at clear count 10, release -> init_busy high a further full 32 cycles; rd_en/wr_en pulsed during busy produce no rd_valid and no change to memory.
- Reset with read in flight: rd_en then rst the next cycle -> rd_valid stays 0, rd_data=0, init_busy=1.

Source files
------------

// File: rtl/ref_shallow_ram_be_init.sv
// rtl/ref_shallow_ram_be_init.sv - shallow distributed RAM with byte enables, read strobe and clear-on-reset
module ref_shallow_ram_be_init #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter bit                    OUT_REG    = 1'b0,
    parameter bit                    BYPASS     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int NUM_WORDS = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_next;
    logic                  clr_we;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_WIDTH-1:0]   mem_be;

    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  stage_valid;
    logic [DATA_WIDTH-1:0] stage_data;

    // Clear FSM state and address counter; reset always restarts the clear at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Clear FSM next state: one INIT_VALUE write per cycle, READY after the last address.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we   = 1'b1;
                cnt_next = cnt + ADDR_WIDTH'(1);
                if (cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_next = READY;
                end
            end
            default: begin
                state_next = READY;
            end
        endcase
    end

    assign init_busy = (state == CLEAR);
    assign rd_fire   = (state == READY) && rd_en;

    // Single write port shared by the clear sequence and user writes; user requests are dropped while clearing.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_be    = wr_be;
        if (!rst) begin
            if (clr_we) begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = INIT_VALUE;
                mem_be    = '1;
            end else if ((state == READY) && wr_en) begin
                mem_we = 1'b1;
            end
        end
    end

    // Byte-masked storage write; array is not reset, the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read word with optional same-address write-through merged per byte.
    always_comb begin
        rd_word = mem[rd_addr];
        if (BYPASS && wr_en && (rd_addr == wr_addr)) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    generate
        if (OUT_REG) begin : g_pipe
            logic                  pipe_valid;
            logic [DATA_WIDTH-1:0] pipe_data;

            // Extra pipeline stage between the array read and the output register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_valid <= 1'b0;
                    pipe_data  <= '0;
                end else begin
                    pipe_valid <= rd_fire;
                    if (rd_fire) begin
                        pipe_data <= rd_word;
                    end
                end
            end

            assign stage_valid = pipe_valid;
            assign stage_data  = pipe_data;
        end else begin : g_direct
            assign stage_valid = rd_fire;
            assign stage_data  = rd_word;
        end
    endgenerate

    // Output register: rd_valid is a one-cycle strobe, rd_data holds until the next completed read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= stage_valid;
            if (stage_valid) begin
                rd_data <= stage_data;
            end
        end
    end

endmodule

// File: tb/tb_ref_shallow_ram_be_init.sv
// tb/tb_ref_shallow_ram_be_init.sv - directed table-driven bench for ref_shallow_ram_be_init
module tb_ref_shallow_ram_be_init;

    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [4:0]  rd_addr;

    logic [31:0] rd_data_a, rd_data_b, rd_data_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic        busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ref_shallow_ram_be_init #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .OUT_REG(1'b0), .BYPASS(1'b1), .INIT_VALUE(INIT)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(busy_a));

    ref_shallow_ram_be_init #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .OUT_REG(1'b0), .BYPASS(1'b0), .INIT_VALUE(INIT)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(busy_b));

    ref_shallow_ram_be_init #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .OUT_REG(1'b1), .BYPASS(1'b1), .INIT_VALUE(INIT)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c), .init_busy(busy_c));

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [3:0]  wr_be;
        logic [31:0] wr_data;
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic        exp_valid;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_be   = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'h01010101 * i) ^ 32'h5A000000;
    endfunction

    // Release reset and count cycles until all instances report the clear done.
    task automatic count_busy(input logic pulse_req, output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        rst = 1'b0;
        if (pulse_req) begin
            wr_en = 1'b1; wr_addr = 5'd5; wr_be = 4'hF; wr_data = 32'h0;
            rd_en = 1'b1; rd_addr = 5'd5;
        end
        while (busy_a && n < 100) begin
            tick();
            n++;
            if (rd_valid_a || rd_valid_b || rd_valid_c) saw_valid = 1'b1;
        end
        idle();
    endtask

    initial begin
        int          n;
        logic        sv;
        logic        prev_valid;
        logic [31:0] prev_data;

        vecs[0]  = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b1, 5'd0,  1'b1, INIT,         INIT};
        vecs[1]  = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b1, 5'd17, 1'b1, INIT,         INIT};
        vecs[2]  = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b1, 5'd31, 1'b1, INIT,         INIT};
        vecs[3]  = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b0, 5'd0,  1'b0, INIT,         INIT};
        vecs[4]  = '{1'b1, 5'd3,  4'hF, 32'h11223344, 1'b0, 5'd0,  1'b0, INIT,         INIT};
        vecs[5]  = '{1'b1, 5'd3,  4'h5, 32'hFFEEDDCC, 1'b0, 5'd0,  1'b0, INIT,         INIT};
        vecs[6]  = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b1, 5'd3,  1'b1, 32'h11EE33CC, 32'h11EE33CC};
        vecs[7]  = '{1'b1, 5'd7,  4'hF, 32'h0,        1'b0, 5'd0,  1'b0, 32'h11EE33CC, 32'h11EE33CC};
        vecs[8]  = '{1'b1, 5'd7,  4'h3, 32'hDEADBEEF, 1'b1, 5'd7,  1'b1, 32'h0000BEEF, 32'h00000000};
        vecs[9]  = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b1, 5'd7,  1'b1, 32'h0000BEEF, 32'h0000BEEF};
        vecs[10] = '{1'b1, 5'd9,  4'h0, 32'h12345678, 1'b1, 5'd9,  1'b1, INIT,         INIT};
        vecs[11] = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b1, 5'd9,  1'b1, INIT,         INIT};
        vecs[12] = '{1'b1, 5'd31, 4'hF, 32'hCAFEF00D, 1'b1, 5'd30, 1'b1, INIT,         INIT};
        vecs[13] = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b1, 5'd31, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[14] = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b0, 5'd0,  1'b0, 32'hCAFEF00D, 32'hCAFEF00D};

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_rd_data_a", rd_data_a, 32'h0);
        chk("reset_rd_valid_a", {31'h0, rd_valid_a}, 32'h0);
        chk("reset_busy_a", {31'h0, busy_a}, 32'h1);
        chk("reset_rd_data_c", rd_data_c, 32'h0);
        chk("reset_busy_c", {31'h0, busy_c}, 32'h1);

        count_busy(1'b0, n, sv);
        chk("clear_busy_cycles", n, 32);
        chk("clear_busy_b", {31'h0, busy_b}, 32'h0);
        chk("clear_busy_c", {31'h0, busy_c}, 32'h0);

        // Table vectors: a/b have latency 1, c (OUT_REG=1, BYPASS=1) lags a by one cycle.
        prev_valid = 1'b0;
        prev_data  = 32'h0;
        for (int k = 0; k < 15; k++) begin
            wr_en   = vecs[k].wr_en;
            wr_addr = vecs[k].wr_addr;
            wr_be   = vecs[k].wr_be;
            wr_data = vecs[k].wr_data;
            rd_en   = vecs[k].rd_en;
            rd_addr = vecs[k].rd_addr;
            tick();
            chk($sformatf("vec%0d_valid_a", k), {31'h0, rd_valid_a}, {31'h0, vecs[k].exp_valid});
            chk($sformatf("vec%0d_data_a", k), rd_data_a, vecs[k].exp_a);
            chk($sformatf("vec%0d_valid_b", k), {31'h0, rd_valid_b}, {31'h0, vecs[k].exp_valid});
            chk($sformatf("vec%0d_data_b", k), rd_data_b, vecs[k].exp_b);
            chk($sformatf("vec%0d_valid_c", k), {31'h0, rd_valid_c}, {31'h0, prev_valid});
            chk($sformatf("vec%0d_data_c", k), rd_data_c, prev_data);
            prev_valid = vecs[k].exp_valid;
            prev_data  = vecs[k].exp_a;
        end
        idle();

        // Fill with a distinct pattern, then stream 32 back-to-back reads.
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_be = 4'hF; wr_data = pat(i);
            tick();
        end
        idle();
        for (int k = 0; k < 34; k++) begin
            rd_en   = (k < 32);
            rd_addr = 5'(k);
            tick();
            chk($sformatf("stream%0d_valid_c", k), {31'h0, rd_valid_c}, {31'h0, (k >= 1 && k <= 32)});
            if (k >= 1 && k <= 32) chk($sformatf("stream%0d_data_c", k), rd_data_c, pat(k - 1));
            if (k < 32) chk($sformatf("stream%0d_data_a", k), rd_data_a, pat(k));
        end
        idle();

        // Reset at clear count 10, then requests pulsed throughout the restarted clear.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("midclear_busy", {31'h0, busy_a}, 32'h1);
        rst = 1'b1;
        tick();
        count_busy(1'b1, n, sv);
        chk("midclear_busy_cycles", n, 32);
        chk("midclear_no_valid", {31'h0, sv}, 32'h0);
        chk("midclear_rd_data_a", rd_data_a, 32'h0);
        rd_en = 1'b1; rd_addr = 5'd5;
        tick();
        rd_addr = 5'd20;
        chk("midclear_addr5_a", rd_data_a, INIT);
        chk("midclear_addr5_b", rd_data_b, INIT);
        tick();
        idle();
        chk("midclear_addr20_a", rd_data_a, INIT);
        tick();
        chk("midclear_addr5_c", rd_data_c, INIT);

        // Read in flight when reset asserts.
        rd_en = 1'b1; rd_addr = 5'd3;
        tick();
        idle();
        rst = 1'b1;
        tick();
        chk("flight_valid_c", {31'h0, rd_valid_c}, 32'h0);
        chk("flight_data_c", rd_data_c, 32'h0);
        chk("flight_busy_c", {31'h0, busy_c}, 32'h1);
        chk("flight_valid_a", {31'h0, rd_valid_a}, 32'h0);
        chk("flight_data_a", rd_data_a, 32'h0);
        tick();
        chk("flight_valid_c_late", {31'h0, rd_valid_c}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
